// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  // Step counter must be able to hold N (it passes N-1 on the last step).
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift the
// whole BCD field left by one, pulling in the next binary MSB at bit 0.
module dabble_step
  import bcd_pkg::*;
#(
  parameter int D = 3
) (
  input  logic [BCD_DIGIT_W*D-1:0] bcd_in,
  input  logic                     msb_in,
  output logic [BCD_DIGIT_W*D-1:0] bcd_out
);

  logic [D-1:0][BCD_DIGIT_W-1:0] corr;
  // Top bit shifted out of the last digit; always 0 when 10^D > 2^N-1.
  logic                          unused_carry;

  for (genvar i = 0; i < D; i++) begin : g_dig
    logic [BCD_DIGIT_W-1:0] dig;
    assign dig     = bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W];
    // Per-digit correction, no carry between digits
    assign corr[i] = (dig >= BCD_DIGIT_W'(ADD3_THRESH)) ? dig + BCD_DIGIT_W'(3) : dig;
  end

  assign {unused_carry, bcd_out} = {corr, msb_in};

endmodule

// File: rtl/bcd_conv_ctrl.sv
// Binary-to-BCD conversion controller, one bit per clock (double dabble).
// Optional leading-zero mask output enabled by macro BCD_CONV_BLANK_EN;
// without it, blank is tied to zero.
module bcd_conv_ctrl
  import bcd_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 3
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     start,
  input  logic [N-1:0]             bin_in,
  output logic                     busy,
  output logic                     done,
  output logic [BCD_DIGIT_W*D-1:0] bcd_out,
  output logic [D-1:0]             blank
);

  localparam int CW = cnt_width(N);
  localparam int BW = BCD_DIGIT_W * D;

  state_t            state;
  // BCD field in the upper BW bits, binary operand in the lower N bits
  logic [BW+N-1:0]   scratch;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bcd_nxt;
  logic              last;

  dabble_step #(.D(D)) u_step (
    .bcd_in (scratch[BW+N-1:N]),
    .msb_in (scratch[N-1]),
    .bcd_out(bcd_nxt)
  );

  assign last = (cnt == CW'(N - 1));

  // Control FSM, scratch/counter datapath and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      scratch <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            scratch <= {BW'(0), bin_in};
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {bcd_nxt, scratch[N-2:0], 1'b0};
          cnt     <= cnt + CW'(1);
          if (last) begin
            bcd_out <= bcd_nxt;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BCD_CONV_BLANK_EN
  logic [D-1:0] blank_nxt;
  logic         zero_above;

  // Leading-zero mask of the result about to be published; digit 0 never blanks
  always_comb begin
    blank_nxt  = '0;
    zero_above = 1'b1;
    for (int i = D - 1; i >= 1; i--) begin
      zero_above   = zero_above & (bcd_nxt[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_nxt[i] = zero_above;
    end
  end

  // blank follows bcd_out: same reset value (a displayed "0") and update edge
  always_ff @(posedge Clock) begin
    if (Reset)
      blank <= ~D'(1);
    else if (state == SHIFT && last)
      blank <= blank_nxt;
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// Scoreboard bench for bcd_conv_ctrl: a cycle-level reference model of the
// accept/complete timing pushes expected results; a negedge monitor checks
// busy/done/bcd_out/blank every cycle and pops results on done.
module tb_bcd_conv_ctrl;

  localparam int N = 8;
  localparam int D = 3;

  logic           Clock;
  logic           Reset;
  logic           start;
  logic [N-1:0]   bin_in;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd_out;
  logic [D-1:0]   blank;

  bcd_conv_ctrl #(.N(N), .D(D)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .bcd_out(bcd_out),
    .blank  (blank)
  );

  typedef struct {
    int val;
    int acc;
  } exp_t;

  exp_t q[$];
  int   n_chk     = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   next_free = 0;
  int   last_acc  = -1000;
  int   last_val  = 0;
  int   hold_val  = 0;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Digit i (i>0) is a leading zero exactly when the value is below 10^i
  function automatic logic [D-1:0] exp_blank(input int v);
    logic [D-1:0] b;
    int p;
    b = '0;
    p = 1;
    for (int i = 1; i < D; i++) begin
      p = p * 10;
      b[i] = (v < p);
    end
`ifndef BCD_CONV_BLANK_EN
    b = '0;
`endif
    return b;
  endfunction

  // Reference model: conversion accepted when idle, result N edges later,
  // next accept possible N+2 edges after an accept; reset discards everything.
  initial begin
    forever begin
      @(posedge Clock);
      cyc++;
      if (Reset) begin
        next_free = cyc + 1;
        last_acc  = -1000;
        hold_val  = 0;
        q.delete();
      end else begin
        if (cyc == last_acc + N) hold_val = last_val;
        if (start && cyc >= next_free) begin
          last_acc  = cyc;
          last_val  = int'(bin_in);
          next_free = cyc + N + 2;
          q.push_back('{val: int'(bin_in), acc: cyc});
        end
      end
    end
  end

  // Monitor: per-cycle output checks, result pop on done
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (cyc > 0) begin
        chk("busy", busy, (cyc >= last_acc && cyc < last_acc + N));
        chk("done", done, (cyc == last_acc + N));
        chk("busy_done_excl", busy & done, 0);
        chk("bcd_hold", bcd_out, to_bcd(hold_val));
        chk("blank", blank, exp_blank(hold_val));
        for (int i = 0; i < D; i++)
          chk("digit_range", (bcd_out[4*i +: 4] <= 4'd9), 1);
        if (done) begin
          if (q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e = q.pop_front();
            chk("done_latency", cyc - e.acc, N);
            chk("result", bcd_out, to_bcd(e.val));
            chk("result_blank", blank, exp_blank(e.val));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  // Single start pulse on the first edge the model says is idle
  task automatic pulse(input int v);
    while (cyc + 1 < next_free) step();
    start  = 1'b1;
    bin_in = N'(v);
    step();
    start  = 1'b0;
  endtask

  // Start held high; returns just after the accept edge for v
  task automatic held(input int v);
    start  = 1'b1;
    bin_in = N'(v);
    while (cyc + 1 < next_free) step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    Reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    wait_cycles(3);
    Reset = 1'b0;

    pulse(0);
    wait_cycles(N + 3);
    pulse(255);
    wait_cycles(N + 3);

    // Back-to-back with start held high
    held(99);
    held(7);
    start = 1'b0;
    wait_cycles(N + 3);

    // Start during SHIFT is ignored, new operand is not sampled
    pulse(200);
    wait_cycles(3);
    start  = 1'b1;
    bin_in = 8'd13;
    step();
    start  = 1'b0;
    wait_cycles(N + 3);

    // Reset mid-SHIFT, together with a start request
    pulse(180);
    wait_cycles(3);
    Reset  = 1'b1;
    start  = 1'b1;
    bin_in = 8'd77;
    step();
    Reset = 1'b0;
    start = 1'b0;
    step();
    pulse(180);
    wait_cycles(N + 3);

    // Full sweep, back-to-back
    for (int v = 0; v < 256; v++) held(v);
    start = 1'b0;
    wait_cycles(N + 3);

    // Random start/operand traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      start  = ($urandom_range(0, 3) == 0);
      bin_in = N'($urandom_range(0, 255));
      Reset  = ($urandom_range(0, 59) == 0);
      step();
    end
    start = 1'b0;
    Reset = 1'b0;
    wait_cycles(N + 4);

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
